// File: rtl/multiword_add_sequencer.sv
// Wide adder reusing one N-bit ripple slice, one word per clock, LSW first.
// Optional subtract port enabled by defining MULTIWORD_ADD_SUB_EN.
module ripple_carry_adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  logic [N:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) |
                    (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[N];

endmodule

module multiword_add_sequencer #(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WORDS-1:0] op1,
  input  logic [N*WORDS-1:0] op2,
  input  logic               carry_in,
`ifdef MULTIWORD_ADD_SUB_EN
  input  logic               sub,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*WORDS-1:0] sum,
  output logic               carry_out,
  output logic               busy
);

  localparam int IW = $clog2(WORDS);
  localparam logic [IW-1:0] LAST =
    IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t                     state;
  logic [IW-1:0]              idx;
  logic                       carry_r;
  logic [WORDS-1:0][N-1:0]    op1_r;
  logic [WORDS-1:0][N-1:0]    op2_r;
  logic [WORDS-1:0][N-1:0]    sum_r;
  logic [N-1:0]               s_sl;
  logic                       c_sl;

  ripple_carry_adder #(.N(N)) u_slice (
    .a    (op1_r[idx]),
    .b    (op2_r[idx]),
    .cin  (carry_r),
    .s    (s_sl),
    .cout (c_sl)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      carry_r <= 1'b0;
      op1_r   <= '0;
      op2_r   <= '0;
      sum_r   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            op1_r <= op1;
            idx   <= '0;
            state <= RUN;
`ifdef MULTIWORD_ADD_SUB_EN
            // Two's-complement subtract: invert op2 once, carry-in of 1.
            if (sub) begin
              op2_r   <= ~op2;
              carry_r <= 1'b1;
            end else begin
              op2_r   <= op2;
              carry_r <= carry_in;
            end
`else
            op2_r   <= op2;
            carry_r <= carry_in;
`endif
          end
        end
        RUN: begin
          sum_r[idx] <= s_sl;
          carry_r    <= c_sl;
          if (idx == LAST) begin
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) ||
                     (state == DONE);
  assign sum       = sum_r;
  assign carry_out = carry_r;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed + random bench for multiword_add_sequencer (N=4, WORDS=4).
// Expected results are queued at acceptance and checked on output.
module tb_multiword_add_sequencer;

  localparam int N = 4;
  localparam int WORDS = 4;
  localparam int W = N * WORDS;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op1 = '0;
  logic [W-1:0] op2 = '0;
  logic         carry_in = 1'b0;
  logic         sub_sel = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         busy;

  logic [W:0]   sb_q[$];
  int           total = 0;
  int           passed = 0;

  always #5 clk = ~clk;

  multiword_add_sequencer #(
    .N     (N),
    .WORDS (WORDS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op1       (op1),
    .op2       (op2),
    .carry_in  (carry_in),
`ifdef MULTIWORD_ADD_SUB_EN
    .sub       (sub_sel),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .busy      (busy)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h",
                tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one operation and take it at the next edge.
  task automatic accept(input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic ci,
                        input bit push,
                        input logic [W:0] exp);
    int n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    check("accept_wait", 32'(n < 50), 32'd1);
    op1 = a;
    op2 = b;
    carry_in = ci;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    if (push) sb_q.push_back(exp);
  endtask

  task automatic get_result(input string tag,
                            output int lat);
    logic [W:0] e;
    lat = 0;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, "_sum"}, 32'(sum), 32'(e[W-1:0]));
      check({tag, "_cout"}, 32'(carry_out), 32'(e[W]));
    end else begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    logic [W:0] e;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic ci;

    step();
    step();
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(carry_out), 32'd0);

    // Simple carry across a word boundary, with latency.
    accept(16'h00FF, 16'h0001, 1'b0, 1'b1, 17'h00100);
    check("t1_busy", 32'(busy), 32'd1);
    get_result("t1", lat);
    check("t1_latency", 32'(lat), 32'd4);

    // Carry ripples through all four words.
    accept(16'hFFFF, 16'h0000, 1'b1, 1'b1, 17'h10000);
    get_result("t2", lat);

    // Stalled output with competing input.
    accept(16'h1111, 16'h2222, 1'b0, 1'b1, 17'h03333);
    lat = 0;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
    end
    op1 = 16'hFFFF;
    op2 = 16'h0001;
    carry_in = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t3_hold_sum", 32'(sum), 32'h3333);
      check("t3_hold_cout", 32'(carry_out), 32'd0);
      check("t3_in_ready", 32'(in_ready), 32'd0);
      check("t3_out_valid", 32'(out_valid), 32'd1);
    end
    void'(sb_q.pop_front());
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t3_idle", 32'(in_ready), 32'd1);
    sb_q.push_back(17'h10000);
    step();
    in_valid = 1'b0;
    check("t3_taken", 32'(busy), 32'd1);
    get_result("t3b", lat);

    // Reset mid-run discards the operation.
    accept(16'hAAAA, 16'h5555, 1'b0, 1'b0, '0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t4_in_ready", 32'(in_ready), 32'd1);
    check("t4_out_valid", 32'(out_valid), 32'd0);
    check("t4_sum", 32'(sum), 32'd0);
    check("t4_cout", 32'(carry_out), 32'd0);
    for (int i = 0; i < 6; i++) step();
    check("t4_no_pulse", 32'(out_valid), 32'd0);
    accept(16'h1234, 16'h4321, 1'b0, 1'b1, 17'h05555);
    get_result("t4b", lat);

`ifdef MULTIWORD_ADD_SUB_EN
    sub_sel = 1'b1;
    accept(16'h0005, 16'h0007, 1'b1, 1'b1, 17'h0FFFE);
    get_result("sub_neg", lat);
    accept(16'h0007, 16'h0005, 1'b0, 1'b1, 17'h10002);
    get_result("sub_pos", lat);
    sub_sel = 1'b0;
`endif

    // Back-to-back stream with out_ready tied high.
    begin
      int acc = 0;
      int got = 0;
      int cyc = 0;
      int last_acc = -1;
      bit pre;
      out_ready = 1'b1;
      a = 16'($urandom);
      b = 16'($urandom);
      ci = 1'($urandom);
      op1 = a;
      op2 = b;
      carry_in = ci;
      in_valid = 1'b1;
      while ((acc < 20 || got < 20) && cyc < 400) begin
        pre = in_ready;
        if (out_valid) begin
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("rnd_sum", 32'(sum), 32'(e[W-1:0]));
            check("rnd_cout", 32'(carry_out), 32'(e[W]));
          end else begin
            check("rnd_sb_empty", 32'd0, 32'd1);
          end
          got++;
        end
        step();
        cyc++;
        if (pre && in_valid) begin
          if (last_acc >= 0)
            check("rnd_spacing", 32'(cyc - last_acc), 32'd6);
          last_acc = cyc;
          sb_q.push_back({1'b0, a} + {1'b0, b} + 17'(ci));
          acc++;
          if (acc < 20) begin
            a = 16'($urandom);
            b = 16'($urandom);
            ci = 1'($urandom);
            op1 = a;
            op2 = b;
            carry_in = ci;
          end else begin
            in_valid = 1'b0;
          end
        end
      end
      check("rnd_timeout", 32'(cyc < 400), 32'd1);
      check("rnd_count", 32'(got), 32'd20);
      out_ready = 1'b0;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multiword_add_sequencer.md
# multiword_add_sequencer

Multi-cycle wide adder controller. Adds two `N*WORDS`-bit operands using a single `N`-bit `ripple_carry_adder` slice, one word per clock, least-significant word first. Carry is held in a register between slices. Operands arrive through a valid/ready input handshake; the result leaves through a valid/ready output handshake. It lets wide additions reuse a narrow adder where area matters more than throughput.

## Interface
Parameters:
- `N`, default 4: slice width in bits; passed to the internal `ripple_carry_adder #(.N(N))`.
- `WORDS`, default 4: number of slices per operand; must be ≥ 2. Operand width is `W = N*WORDS`.

Ports:
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst`  input  1: synchronous reset, active-high.
- `in_valid`  input  1: operands and `carry_in` are valid.
- `in_ready`  output  1: block accepts new operands. High only in IDLE.
- `op1`  input  W: first operand.
- `op2`  input  W: second operand.
- `carry_in`  input  1: carry into word 0.
- `sub`  input  1: select subtraction. Present only with `MULTIWORD_ADD_SUB_EN`.
- `out_valid`  output  1: `sum`/`carry_out` valid. High only in DONE.
- `out_ready`  input  1: consumer takes the result.
- `sum`  output  W: result register.
- `carry_out`  output  1: carry out of the top slice.
- `busy`  output  1: high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE. Word index register `idx` has width `$clog2(WORDS)`.
- IDLE:
  - `in_ready=1`.
  - On `in_valid` high at an edge: latch `op1`, `op2` into operand registers; carry register ← `carry_in`; `idx` ← 0; go to RUN.
- RUN, each edge:
  - Adder slice inputs are `op1_r[idx*N +: N]`, `op2_r[idx*N +: N]` and the carry register.
  - Write the slice sum to `sum[idx*N +: N]`; carry register ← slice cout.
  - If `idx==WORDS-1`: go to DONE. Otherwise `idx` increments.
  - `in_valid` is ignored.
- DONE:
  - `out_valid=1`; `carry_out` = carry register.
  - `sum` and `carry_out` are held stable until the output handshake (`out_valid && out_ready` at an edge), then go to IDLE.
- Arithmetic: `{carry_out,sum} == op1 + op2 + carry_in`, modulo 2^(W+1). There is no overflow flag.
- Reset at any state, including mid-RUN or DONE with a pending result:
  - state ← IDLE, `sum` ← 0, carry register ← 0, `idx` ← 0.
  - Any in-flight operation is discarded with no `out_valid` pulse.
- Reset values: `in_ready=1`, `out_valid=0`, `busy=0`, `sum=0`, `carry_out=0`.
- `in_valid` and `out_ready` asserted in the same cycle: only the handshake legal for the current state has effect.

## Timing
- Input handshake at edge t0 (IDLE→RUN).
- Slices are computed at edges t0+1 … t0+WORDS. DONE is entered at edge t0+WORDS, so `out_valid` is high in the cycle after it.
- Latency from acceptance to first `out_valid`: WORDS cycles.
- Earliest output handshake is edge t0+WORDS+1 (IDLE again). The earliest next acceptance is edge t0+WORDS+2.
- Maximum throughput: one operation per WORDS+2 cycles. Operations never overlap.
- All outputs are registered or decoded from the state register only. There is no combinational path from inputs to outputs.

## Configuration
- `MULTIWORD_ADD_SUB_EN` defined:
  - The `sub` port exists and is latched together with the operands.
  - With `sub=1`, the adder sees `~op2_r` slices, and the carry register is loaded with 1; `carry_in` is ignored.
  - Result: `sum = op1 - op2` mod 2^W, and `carry_out = 1` iff `op1 ≥ op2` (unsigned, no borrow).
  - With `sub=0`, behaviour equals the add path.
- Not defined: no `sub` port; addition only.

## Test plan
All scenarios use `N=4`, `WORDS=4` (W=16).
- 0x00FF + 0x0001, `carry_in=0` → `sum=0x0100`, `carry_out=0`; `out_valid` rises exactly 4 cycles after acceptance.
- 0xFFFF + 0x0000, `carry_in=1` → `sum=0x0000`, `carry_out=1`; carry ripples through all 4 words.
- Result pending with `out_ready=0` for 3 cycles and `in_valid=1` with new operands → `sum`/`carry_out` stay stable, `in_ready=0`, new operands not taken; `out_ready=1` → IDLE, then new operands accepted.
- `rst` pulsed after 2 slices of 0xAAAA+0x5555 → next cycle `in_ready=1`, `out_valid=0`, `sum=0`; then 0x1234+0x4321 → `sum=0x5555`, `carry_out=0`.
- `MULTIWORD_ADD_SUB_EN`: 0x0005−0x0007 → `sum=0xFFFE`, `carry_out=0`; 0x0007−0x0005 → `sum=0x0002`, `carry_out=1`.
- `out_ready` tied 1, `in_valid` held 1 with 20 random operand pairs → each result matches `op1+op2+carry_in`; accepts spaced exactly 6 cycles apart.
